proc_cmd_sequencer: RTL and testbench

Command sequencer that drives the control inputs of `processor`: mode, F, read_addr1/2, dest_addr, store_addr and store_data.
- Accepts one vector command over a valid/ready handshake.
- Expands it into `len` back-to-back single-cycle operations, auto-incrementing addresses and store data.
- Replaces hand-written per-element stimulus loops; a host or a test FSM upstream issues whole register-file fills or element-wise ALU passes as one command.
- Register 0 is the discard destination; all idle outputs target it.

---
 rtl/proc_cmd_sequencer.sv | 147 ++++++++++++++
 tb/tb_proc_cmd_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_cmd_sequencer.sv
// Expands one vector command into len back-to-back processor operations with auto-incremented addresses/data.
// Define PROC_SEQ_PERF_CNT_EN to add the saturating ops_issued / cmds_done counters.
module proc_cmd_sequencer #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_mode,
   input  logic [2:0]        cmd_f,
   input  logic [ADDR_W-1:0] cmd_src1,
   input  logic [ADDR_W-1:0] cmd_src2,
   input  logic [ADDR_W-1:0] cmd_dest,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic [2:0]        cmd_inc,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              mode,
   output logic [2:0]        F,
   output logic [ADDR_W-1:0] read_addr1,
   output logic [ADDR_W-1:0] read_addr2,
   output logic [ADDR_W-1:0] dest_addr,
   output logic [ADDR_W-1:0] store_addr,
   output logic [DATA_W-1:0] store_data
`ifdef PROC_SEQ_PERF_CNT_EN
   ,
   output logic [15:0]       ops_issued,
   output logic [15:0]       cmds_done
`endif
);

   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
   state_t state, state_nx;

   logic              c_mode;
   logic [2:0]        c_f, c_inc;
   logic [ADDR_W-1:0] c_src1, c_src2, c_dest;
   logic [DATA_W-1:0] c_data;
   logic [LEN_W-1:0]  c_len, k, k_nx;
   logic              accept, last;

   logic              s_mode;
   logic [2:0]        s_f, s_inc;
   logic [ADDR_W-1:0] s_src1, s_src2, s_dest, t_dest;
   logic [DATA_W-1:0] s_data;

   logic              mode_nx;
   logic [2:0]        f_nx;
   logic [ADDR_W-1:0] ra1_nx, ra2_nx, da_nx, sa_nx;
   logic [DATA_W-1:0] sd_nx;

   assign accept = cmd_valid && cmd_ready;
   assign last   = (k == c_len - LEN_W'(1));

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = (cmd_len == '0) ? DONE : ISSUE;
         ISSUE:   if (abort || last) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // In IDLE the element-0 values come straight from the command inputs so they land at the accept edge.
   always_comb begin
      cmd_ready = (state == IDLE) && rst_n && !abort;
      busy      = (state == ISSUE);
      done      = (state == DONE);
      if (state == IDLE) begin
         s_mode = cmd_mode;  s_f    = cmd_f;    s_inc  = cmd_inc;
         s_src1 = cmd_src1;  s_src2 = cmd_src2; s_dest = cmd_dest;
         s_data = cmd_data;  k_nx   = '0;
      end else begin
         s_mode = c_mode;    s_f    = c_f;      s_inc  = c_inc;
         s_src1 = c_src1;    s_src2 = c_src2;   s_dest = c_dest;
         s_data = c_data;    k_nx   = k + LEN_W'(1);
      end
      t_dest  = s_dest + (s_inc[2] ? ADDR_W'(k_nx) : '0);
      mode_nx = 1'b0;
      f_nx    = '0;
      ra1_nx  = '0;
      ra2_nx  = '0;
      da_nx   = '0;
      sa_nx   = '0;
      sd_nx   = '0;
      if (state_nx == ISSUE) begin
         if (s_mode) begin
            mode_nx = 1'b1;
            sa_nx   = t_dest;
            sd_nx   = s_data + (s_inc[2] ? DATA_W'(k_nx) : '0);
         end else begin
            f_nx   = s_f;
            ra1_nx = s_src1 + (s_inc[0] ? ADDR_W'(k_nx) : '0);
            ra2_nx = s_src2 + (s_inc[1] ? ADDR_W'(k_nx) : '0);
            da_nx  = t_dest;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         c_mode <= 1'b0; c_f <= '0; c_inc <= '0;
         c_src1 <= '0; c_src2 <= '0; c_dest <= '0;
         c_data <= '0; c_len <= '0; k <= '0;
         mode <= 1'b0; F <= '0; read_addr1 <= '0; read_addr2 <= '0;
         dest_addr <= '0; store_addr <= '0; store_data <= '0;
      end else begin
         if (accept) begin
            c_mode <= cmd_mode; c_f <= cmd_f; c_inc <= cmd_inc;
            c_src1 <= cmd_src1; c_src2 <= cmd_src2; c_dest <= cmd_dest;
            c_data <= cmd_data; c_len <= cmd_len;
         end
         k          <= (state_nx == ISSUE) ? k_nx : '0;
         mode       <= mode_nx;
         F          <= f_nx;
         read_addr1 <= ra1_nx;
         read_addr2 <= ra2_nx;
         dest_addr  <= da_nx;
         store_addr <= sa_nx;
         store_data <= sd_nx;
      end
   end

`ifdef PROC_SEQ_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ops_issued <= '0;
         cmds_done  <= '0;
      end else begin
         if (busy && ops_issued != 16'hFFFF) ops_issued <= ops_issued + 16'd1;
         if (done && cmds_done  != 16'hFFFF) cmds_done  <= cmds_done + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_proc_cmd_sequencer.sv
// Bench for proc_cmd_sequencer: queue-based expected-output model plus directed literal checks and random traffic.
module tb_proc_cmd_sequencer;
   localparam int AW = 5;
   localparam int DW = 32;
   localparam int LW = 5;

   logic          clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, cmd_mode = 1'b0, abort = 1'b0;
   logic [2:0]    cmd_f = '0, cmd_inc = '0;
   logic [AW-1:0] cmd_src1 = '0, cmd_src2 = '0, cmd_dest = '0;
   logic [DW-1:0] cmd_data = '0;
   logic [LW-1:0] cmd_len = '0;
   logic          cmd_ready, busy, done, mode;
   logic [2:0]    F;
   logic [AW-1:0] read_addr1, read_addr2, dest_addr, store_addr;
   logic [DW-1:0] store_data;
`ifdef PROC_SEQ_PERF_CNT_EN
   logic [15:0]   ops_issued, cmds_done;
`endif

   always #5 clk = ~clk;

   proc_cmd_sequencer #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_mode(cmd_mode), .cmd_f(cmd_f), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2),
      .cmd_dest(cmd_dest), .cmd_data(cmd_data), .cmd_len(cmd_len), .cmd_inc(cmd_inc),
      .abort(abort), .busy(busy), .done(done), .mode(mode), .F(F),
      .read_addr1(read_addr1), .read_addr2(read_addr2), .dest_addr(dest_addr),
      .store_addr(store_addr), .store_data(store_data)
`ifdef PROC_SEQ_PERF_CNT_EN
      , .ops_issued(ops_issued), .cmds_done(cmds_done)
`endif
   );

   typedef struct {
      logic          mode;
      logic [2:0]    f;
      logic [AW-1:0] ra1, ra2, da, sa;
      logic [DW-1:0] sd;
      logic          busy, done;
   } exp_t;

   exp_t q[$];
   exp_t cur;
   int   vectors = 0;
   int   miscompares = 0;
   int   m_ops = 0;
   int   m_cmds = 0;

   function automatic exp_t idle_e();
      exp_t e;
      e.mode = 1'b0; e.f = '0; e.ra1 = '0; e.ra2 = '0; e.da = '0; e.sa = '0;
      e.sd = '0; e.busy = 1'b0; e.done = 1'b0;
      return e;
   endfunction

   function automatic exp_t done_e();
      exp_t e = idle_e();
      e.done = 1'b1;
      return e;
   endfunction

   // Element k of the command currently on the cmd_* inputs.
   function automatic exp_t elem(int k);
      exp_t e = idle_e();
      logic [AW-1:0] tgt;
      tgt = cmd_dest + (cmd_inc[2] ? AW'(k) : AW'(0));
      e.busy = 1'b1;
      if (cmd_mode) begin
         e.mode = 1'b1;
         e.sa   = tgt;
         e.sd   = cmd_data + (cmd_inc[2] ? DW'(k) : DW'(0));
      end else begin
         e.f   = cmd_f;
         e.ra1 = cmd_src1 + (cmd_inc[0] ? AW'(k) : AW'(0));
         e.ra2 = cmd_src2 + (cmd_inc[1] ? AW'(k) : AW'(0));
         e.da  = tgt;
      end
      return e;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Called at a negedge after inputs are set: checks cmd_ready, advances the model, then checks outputs.
   task automatic tick();
      logic idle, acc;
      #1;
      idle = (q.size() == 0) && !cur.busy && !cur.done;
      chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, rst_n && idle && !abort});
      acc = cmd_valid && rst_n && idle && !abort;
      if (!rst_n) begin
         q.delete();
         m_ops  = 0;
         m_cmds = 0;
         cur    = idle_e();
      end else begin
         if (cur.busy && m_ops < 65535) m_ops++;
         if (cur.done && m_cmds < 65535) m_cmds++;
         if (acc) begin
            for (int k = 0; k < int'(cmd_len); k++) q.push_back(elem(k));
            q.push_back(done_e());
         end else if (cur.busy && abort) begin
            q.delete();
            q.push_back(done_e());
         end
         cur = (q.size() != 0) ? q.pop_front() : idle_e();
      end
      @(posedge clk);
      @(negedge clk);
      chk("busy", {31'b0, busy}, {31'b0, cur.busy});
      chk("done", {31'b0, done}, {31'b0, cur.done});
      chk("mode", {31'b0, mode}, {31'b0, cur.mode});
      chk("F", {29'b0, F}, {29'b0, cur.f});
      chk("read_addr1", 32'(read_addr1), 32'(cur.ra1));
      chk("read_addr2", 32'(read_addr2), 32'(cur.ra2));
      chk("dest_addr", 32'(dest_addr), 32'(cur.da));
      chk("store_addr", 32'(store_addr), 32'(cur.sa));
      chk("store_data", store_data, cur.sd);
`ifdef PROC_SEQ_PERF_CNT_EN
      chk("ops_issued", 32'(ops_issued), 32'(m_ops));
      chk("cmds_done", 32'(cmds_done), 32'(m_cmds));
`endif
   endtask

   task automatic send(input logic m, input logic [2:0] f, input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                       input logic [AW-1:0] d, input logic [DW-1:0] dat, input logic [LW-1:0] len,
                       input logic [2:0] inc);
      cmd_mode = m; cmd_f = f; cmd_src1 = s1; cmd_src2 = s2; cmd_dest = d;
      cmd_data = dat; cmd_len = len; cmd_inc = inc;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] wrap_sa [4];
      logic [31:0] wrap_sd [4];
      wrap_sa = '{32'd30, 32'd31, 32'd0, 32'd1};
      wrap_sd = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1};
      cur = idle_e();

      repeat (3) tick();
      chk("rst_ready", {31'b0, cmd_ready}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Store fill: addresses 1..10, data 5..14, done after element 9.
      send(1'b1, 3'b000, '0, '0, 5'd1, 32'd5, 5'd10, 3'b100);
      for (int i = 0; i < 10; i++) begin
         chk("st_addr", 32'(store_addr), 32'(1 + i));
         chk("st_data", store_data, 32'(5 + i));
         tick();
      end
      chk("st_done", {31'b0, done}, 32'd1);
      tick();

      // ALU pass: src1 1..10, src2 11..20, dest fixed at 21.
      send(1'b0, 3'b100, 5'd1, 5'd11, 5'd21, 32'd0, 5'd10, 3'b011);
      for (int i = 0; i < 10; i++) begin
         chk("alu_ra1", 32'(read_addr1), 32'(1 + i));
         chk("alu_ra2", 32'(read_addr2), 32'(11 + i));
         chk("alu_da", 32'(dest_addr), 32'd21);
         chk("alu_f", {29'b0, F}, 32'd4);
         tick();
      end
      chk("alu_done", {31'b0, done}, 32'd1);
      chk("alu_idle", 32'(read_addr1), 32'd0);
      tick();

      // Abort during element 3 of a len=8 store.
      send(1'b1, 3'b000, '0, '0, 5'd3, 32'd100, 5'd8, 3'b100);
      repeat (3) tick();
      chk("ab_el3", 32'(store_addr), 32'd6);
      abort = 1'b1;
      tick();
      chk("ab_done", {31'b0, done}, 32'd1);
      chk("ab_idle", 32'(store_addr), 32'd0);
      abort = 1'b0;
      tick();
`ifdef PROC_SEQ_PERF_CNT_EN
      chk("perf_ops24", 32'(ops_issued), 32'd24);
      chk("perf_cmds3", 32'(cmds_done), 32'd3);
`endif

      // Abort in IDLE blocks acceptance.
      cmd_len = 5'd3; cmd_valid = 1'b1; abort = 1'b1;
      tick();
      chk("idle_abort", {31'b0, busy}, 32'd0);
      cmd_valid = 1'b0; abort = 1'b0;
      tick();

      // Address and data wrap.
      send(1'b1, 3'b000, '0, '0, 5'd30, 32'hFFFFFFFE, 5'd4, 3'b100);
      for (int i = 0; i < 4; i++) begin
         chk("wr_addr", 32'(store_addr), wrap_sa[i]);
         chk("wr_data", store_data, wrap_sd[i]);
         tick();
      end
      chk("wr_done", {31'b0, done}, 32'd1);
      tick();

      // len=0 then a back-to-back command two cycles later.
      send(1'b1, 3'b000, '0, '0, 5'd7, 32'd9, 5'd0, 3'b100);
      chk("l0_done", {31'b0, done}, 32'd1);
      chk("l0_idle", {31'b0, mode}, 32'd0);
      cmd_len = 5'd2; cmd_valid = 1'b1;
      tick();
      tick();
      chk("l0_next", {31'b0, busy}, 32'd1);
      cmd_valid = 1'b0;
      repeat (3) tick();

      // Reset mid-sequence: outputs idle, no done.
      send(1'b1, 3'b000, '0, '0, 5'd2, 32'd1, 5'd6, 3'b100);
      tick();
      rst_n = 1'b0;
      tick();
      chk("rs_busy", {31'b0, busy}, 32'd0);
      chk("rs_addr", 32'(store_addr), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("rs_nodone", {31'b0, done}, 32'd0);

      for (int n = 0; n < 1500; n++) begin
         cmd_mode  = 1'($urandom_range(0, 1));
         cmd_f     = 3'($urandom);
         cmd_src1  = AW'($urandom);
         cmd_src2  = AW'($urandom);
         cmd_dest  = AW'($urandom);
         cmd_data  = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFF - 32'($urandom_range(0, 3))) : $urandom;
         cmd_len   = ($urandom_range(0, 7) == 0) ? LW'($urandom) : LW'($urandom_range(0, 6));
         cmd_inc   = 3'($urandom);
         cmd_valid = 1'($urandom_range(0, 1));
         abort     = ($urandom_range(0, 11) == 0);
         rst_n     = ($urandom_range(0, 59) != 0);
         tick();
      end
      cmd_valid = 1'b0; abort = 1'b0; rst_n = 1'b1;
      repeat (40) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
